// File: rtl/ram_arbiter_pkg.sv
// Shared widths and state encoding for the SRAM arbiter.
// RAM_ARB_WAIT_EN adds one extra read-wait and one extra write-pulse state.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int RAM_ADDR_W_DEF = 18;
  localparam int DATA_W_DEF     = 16;

`ifdef RAM_ARB_WAIT_EN
  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_WAIT, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_PULSE2, WR_HOLD
  } arb_state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD
  } arb_state_t;
`endif

endpackage

// File: rtl/ram_timing_fsm.sv
// SRAM cycle sequencer: state register, next-state logic and strobe decode.
// Latency: read 2 states (3 with RAM_ARB_WAIT_EN), write 3 (4); done marks the final state.
// Backpressure: none; a grant taken in IDLE or a final state starts the next cycle immediately.
module ram_timing_fsm
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic is_write,
  output logic arb_en,
  output logic done,
  output logic rd_capture,
  output logic ram_ce_n,
  output logic ram_oe_n,
  output logic ram_we_n,
  output logic ram_data_oe
);

  arb_state_t state_q, state_d, next_setup;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Kept out of the next-state block so the arbiter's grant path has no false loop.
  assign done   = (state_q == RD_SAMPLE) || (state_q == WR_HOLD);
  assign arb_en = (state_q == IDLE) || done;
`ifdef RAM_ARB_WAIT_EN
  assign rd_capture = (state_q == RD_WAIT);
`else
  assign rd_capture = (state_q == RD_SETUP);
`endif

  assign next_setup = is_write ? WR_SETUP : RD_SETUP;

  always_comb begin
    state_d     = state_q;
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_data_oe = 1'b0;
    case (state_q)
      IDLE: if (grant) state_d = next_setup;
      RD_SETUP: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
`ifdef RAM_ARB_WAIT_EN
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
`endif
        state_d  = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        state_d  = grant ? next_setup : IDLE;
      end
      WR_SETUP: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        state_d     = WR_PULSE;
      end
      WR_PULSE: begin
        ram_ce_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_data_oe = 1'b1;
`ifdef RAM_ARB_WAIT_EN
        state_d     = WR_PULSE2;
      end
      WR_PULSE2: begin
        ram_ce_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_data_oe = 1'b1;
`endif
        state_d     = WR_HOLD;
      end
      WR_HOLD: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        state_d     = grant ? next_setup : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SRAM between fetch and MEM (MEM wins; read+write together is a write); RAM_ARB_WAIT_EN adds wait states.
// Latency: grant to ready 2 cycles read / 3 write (3 / 4 with RAM_ARB_WAIT_EN); ready is a 1-cycle pulse.
// Backpressure: stall_request holds the pipeline while any request is pending and not yet ready.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_data_o,
  output logic                  if_ready_o,
  input  logic                  rMem_i,
  input  logic                  wMem_i,
  input  logic [ADDR_W-1:0]     memAddr_i,
  input  logic [DATA_W-1:0]     wData_mem_i,
  output logic [DATA_W-1:0]     rData_mem_o,
  output logic                  mem_ready_o,
  output logic                  stall_request,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  input  logic [DATA_W-1:0]     ram_rdata_i,
  output logic                  ram_data_oe_o,
  output logic                  ram_ce_n_o,
  output logic                  ram_oe_n_o,
  output logic                  ram_we_n_o
);

  logic              mem_req, mem_req_eff, if_req_eff;
  logic              arb_en, done, rd_capture, grant, grant_write;
  logic              owner_if;
  logic [ADDR_W-1:0] grant_addr;

  // In a final state the requester just being completed is excluded from arbitration.
  assign mem_req     = rMem_i | wMem_i;
  assign mem_req_eff = mem_req  & ~(done & ~owner_if);
  assign if_req_eff  = if_req_i & ~(done &  owner_if);
  assign grant       = arb_en & (mem_req_eff | if_req_eff);
  assign grant_write = mem_req_eff & wMem_i;
  assign grant_addr  = mem_req_eff ? memAddr_i : if_addr_i;

  ram_timing_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .grant       (grant),
    .is_write    (grant_write),
    .arb_en      (arb_en),
    .done        (done),
    .rd_capture  (rd_capture),
    .ram_ce_n    (ram_ce_n_o),
    .ram_oe_n    (ram_oe_n_o),
    .ram_we_n    (ram_we_n_o),
    .ram_data_oe (ram_data_oe_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_if    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      if_data_o   <= '0;
      rData_mem_o <= '0;
    end else begin
      if (grant) begin
        owner_if   <= ~mem_req_eff;
        ram_addr_o <= RAM_ADDR_W'(grant_addr);
        if (grant_write) ram_wdata_o <= wData_mem_i;
      end
      // Sampled on the edge into RD_SAMPLE so the word is valid alongside ready.
      if (rd_capture) begin
        if (owner_if) if_data_o   <= ram_rdata_i;
        else          rData_mem_o <= ram_rdata_i;
      end
    end
  end

  assign if_ready_o    = done &  owner_if & ~rst;
  assign mem_ready_o   = done & ~owner_if & ~rst;
  assign stall_request = (mem_req & ~mem_ready_o) | (if_req_i & ~if_ready_o);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: single-transaction vector table plus
// hand-written priority, back-to-back and mid-write reset sequences.
module tb_ram_arbiter;

`ifdef RAM_ARB_WAIT_EN
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 4;
  localparam int WE_LEN = 2;
`else
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 3;
  localparam int WE_LEN = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, rmem, wmem;
  logic [15:0] if_addr, mem_addr, wdata, rdata_drv;
  logic [15:0] if_data, rdata_mem, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, stall;
  logic [17:0] ram_addr;
  logic        data_oe, ce_n, oe_n, we_n;
  logic        model_en;

  always #5 clk = ~clk;

  // Simple SRAM model for multi-transaction sequences: word = address + 0x1000.
  assign ram_rdata = model_en ? (ram_addr[15:0] + 16'h1000) : rdata_drv;

  ram_arbiter #(.ADDR_W(16), .RAM_ADDR_W(18), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
    .rMem_i(rmem), .wMem_i(wmem), .memAddr_i(mem_addr), .wData_mem_i(wdata),
    .rData_mem_o(rdata_mem), .mem_ready_o(mem_ready), .stall_request(stall),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .ram_data_oe_o(data_oe), .ram_ce_n_o(ce_n), .ram_oe_n_o(oe_n), .ram_we_n_o(we_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req, rmem, wmem;
    logic [15:0] addr, wdata, rdata;
    logic [17:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vec_t t;
    logic is_wr, is_if, tgt, oth;
    logic [17:0] addr_seen;
    logic [15:0] exp_ifd, exp_memd;
    int lat, mem_lat, if_lat, exp_lat, rdy_n, oth_n;
    int oe_cnt, we_cnt, ce_cnt, doe_cnt, stall_cnt;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 18'h00010, 16'hA5A5};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h4000, 16'h1234, 16'hFFFF, 18'h04000, 16'h1234};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h5A3C, 18'h0FFFF, 16'h5A3C};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0123, 16'hBEEF, 16'h9999, 18'h00123, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h0000, 18'h08001, 16'h0000};

    rst = 1'b1; if_req = 1'b0; rmem = 1'b0; wmem = 1'b0;
    if_addr = '0; mem_addr = '0; wdata = '0; rdata_drv = '0; model_en = 1'b0;
    exp_ifd = '0; exp_memd = '0;

    // Reset values; stall stays combinational during reset.
    repeat (2) @(posedge clk);
    #1 if_req = 1'b1;
    @(negedge clk);
    chk("rst ce_n", ce_n, 1); chk("rst oe_n", oe_n, 1); chk("rst we_n", we_n, 1);
    chk("rst data_oe", data_oe, 0); chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wdata", ram_wdata, 0); chk("rst if_data", if_data, 0);
    chk("rst rdata_mem", rdata_mem, 0); chk("rst if_ready", if_ready, 0);
    chk("rst mem_ready", mem_ready, 0); chk("rst stall", stall, 1);
    if_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      t = vecs[v];
      is_wr = t.wmem; is_if = t.if_req;
      exp_lat = is_wr ? WR_LAT : RD_LAT;
      if_req = t.if_req; rmem = t.rmem; wmem = t.wmem;
      if_addr = t.addr; mem_addr = t.addr; wdata = t.wdata; rdata_drv = t.rdata;
      lat = -1; rdy_n = 0; oth_n = 0; addr_seen = '0;
      oe_cnt = 0; we_cnt = 0; ce_cnt = 0; doe_cnt = 0; stall_cnt = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        tgt = is_if ? if_ready : mem_ready;
        oth = is_if ? mem_ready : if_ready;
        if (!oe_n) oe_cnt++;
        if (!we_n) we_cnt++;
        if (!ce_n) ce_cnt++;
        if (data_oe) doe_cnt++;
        if (stall) stall_cnt++;
        if (oth) oth_n++;
        if (c == 1) addr_seen = ram_addr;
        if (tgt) begin
          rdy_n++;
          if (lat < 0) lat = c;
        end
        @(posedge clk);
        #1;
        if (lat >= 0) begin if_req = 1'b0; rmem = 1'b0; wmem = 1'b0; end
      end
      chk($sformatf("v%0d latency", v), lat, exp_lat);
      chk($sformatf("v%0d ready width", v), rdy_n, 1);
      chk($sformatf("v%0d other ready", v), oth_n, 0);
      chk($sformatf("v%0d oe_n cycles", v), oe_cnt, is_wr ? 0 : RD_LAT);
      chk($sformatf("v%0d we_n cycles", v), we_cnt, is_wr ? WE_LEN : 0);
      chk($sformatf("v%0d ce_n cycles", v), ce_cnt, exp_lat);
      chk($sformatf("v%0d data_oe cycles", v), doe_cnt, is_wr ? WR_LAT : 0);
      chk($sformatf("v%0d stall cycles", v), stall_cnt, exp_lat);
      chk($sformatf("v%0d ram_addr", v), addr_seen, t.exp_addr);
      chk($sformatf("v%0d idle ce_n", v), ce_n, 1);
      if (is_wr) chk($sformatf("v%0d ram_wdata", v), ram_wdata, t.exp_data);
      else if (is_if) exp_ifd = t.exp_data;
      else exp_memd = t.exp_data;
      chk($sformatf("v%0d if_data", v), if_data, exp_ifd);
      chk($sformatf("v%0d rdata_mem", v), rdata_mem, exp_memd);
    end

    // Load and fetch together: load first, fetch setup immediately after, no IDLE.
    model_en = 1'b1;
    rmem = 1'b1; mem_addr = 16'h0020; if_req = 1'b1; if_addr = 16'h0030;
    mem_lat = -1; if_lat = -1;
    for (int c = 0; c < 2 * RD_LAT + 4; c++) begin
      @(negedge clk);
      if (mem_ready && mem_lat < 0) mem_lat = c;
      if (if_ready && if_lat < 0) if_lat = c;
      if (c == RD_LAT) chk("sim stall at mem ready", stall, 1);
      if (c == RD_LAT + 1) begin
        chk("sim no bubble ce_n", ce_n, 0);
        chk("sim no bubble oe_n", oe_n, 0);
        chk("sim fetch addr", ram_addr, 18'h00030);
      end
      @(posedge clk);
      #1;
      if (mem_lat >= 0) rmem = 1'b0;
      if (if_lat >= 0) if_req = 1'b0;
    end
    chk("sim mem latency", mem_lat, RD_LAT);
    chk("sim fetch ready cycle", if_lat, 2 * RD_LAT);
    chk("sim rdata_mem", rdata_mem, 16'h1020);
    chk("sim if_data", if_data, 16'h1030);
    model_en = 1'b0;

    // Reset during the write pulse: idle strobes, cleared outputs, no ready.
    wmem = 1'b1; mem_addr = 16'h0BAD; wdata = 16'h7777;
    repeat (3) @(negedge clk);
    chk("rstw in pulse we_n", we_n, 0);
    rst = 1'b1; wmem = 1'b0;
    @(negedge clk);
    chk("rstw ce_n", ce_n, 1); chk("rstw oe_n", oe_n, 1); chk("rstw we_n", we_n, 1);
    chk("rstw data_oe", data_oe, 0); chk("rstw mem_ready", mem_ready, 0);
    chk("rstw ram_addr", ram_addr, 0); chk("rstw if_data", if_data, 0);
    chk("rstw rdata_mem", rdata_mem, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_ready || if_ready) rdy_n++;
    end
    chk("rstw no late ready", rdy_n, 0);
    chk("rstw stall idle", stall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, expected finish well before", $time);
    $fatal(1, "timeout");
  end

endmodule
